data_frame_scheduler: RTL and testbench

- Sequences the triggered serial data link to the DDS board and shares it between two word sources, e.g. front-panel switches and host.
- On each trigger it arbitrates one pending 18-bit word and emits the fixed frame: start flag, serial data burst (LSB first), end flag.
- All timing is counted in TenMHzToData cycles (100 ns).
- Sits between the request sources and the dflag/data_output pins.

---
 rtl/data_frame_scheduler.sv | 152 +++++++++++++++
 tb/tb_data_frame_scheduler.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/data_frame_scheduler.sv
// data_frame_scheduler
// Sequences the triggered serial link to the DDS board and shares it between
// two word sources. Each trigger rising edge grants one pending source
// (round-robin) and emits a start flag, an LSB-first data burst and an end
// flag. Timing is counted in TenMHzToData cycles.
//
// Ports:
//   TenMHzToData  system clock
//   rst           asynchronous active-high reset
//   trgger        asynchronous frame trigger (rising edge starts a frame)
//   req[1:0]      per-source request level, held until ack
//   data0/data1   source words, stable while the matching req is set
//   ack[1:0]      one-cycle pulse, word of that source latched
//   data_output   serial data line
//   dflag         start/end frame flag
//   busy          high from grant to end of HOLD
//   done          one-cycle pulse on frame completion
//   abort         one-cycle pulse when a frame is cut short
//   missed[7:0]   saturating count of triggers with no request pending
module data_frame_scheduler #(
  parameter int unsigned WIDTH   = 18,
  parameter int unsigned T_START = 8000,
  parameter int unsigned T_DATA  = 10000,
  parameter int unsigned T_END   = 11000,
  parameter int unsigned T_FLAG  = 1000,
  parameter int unsigned T_FRAME = 12000,
  parameter int unsigned CW      = 14
) (
  input  logic             TenMHzToData,
  input  logic             rst,
  input  logic             trgger,
  input  logic [1:0]       req,
  input  logic [WIDTH-1:0] data0,
  input  logic [WIDTH-1:0] data1,
  output logic [1:0]       ack,
  output logic             data_output,
  output logic             dflag,
  output logic             busy,
  output logic             done,
  output logic             abort,
  output logic [7:0]       missed
);

  localparam logic [CW-1:0] C_START     = CW'(T_START);
  localparam logic [CW-1:0] C_START_END = CW'(T_START + T_FLAG);
  localparam logic [CW-1:0] C_END       = CW'(T_END);
  localparam logic [CW-1:0] C_END_END   = CW'(T_END + T_FLAG);
  localparam logic [CW-1:0] C_DATA      = CW'(T_DATA);
  localparam logic [CW-1:0] C_DATA_END  = CW'(T_DATA + WIDTH);
  localparam logic [CW-1:0] C_FRAME     = CW'(T_FRAME);

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

  state_t           state;
  logic [CW-1:0]    counter;
  logic [WIDTH-1:0] shift_reg;
  logic             last_grant;
  // [0],[1]: two-flop synchroniser; [2]: previous synchronised level
  logic [2:0]       trig_sync;

  logic trig_rise;
  logic trig_low;
  logic grant;
  logic flag_on;
  logic bit_on;

  always_comb begin
    trig_rise = trig_sync[1] & ~trig_sync[2];
    trig_low  = ~trig_sync[1];
    // Both pending: pick the source that did not win last time.
    if (req == 2'b11) grant = ~last_grant;
    else              grant = req[1];
    flag_on = ((counter >= C_START) && (counter < C_START_END)) ||
              ((counter >= C_END)   && (counter < C_END_END));
    bit_on  = (counter >= C_DATA) && (counter < C_DATA_END);
  end

  always_ff @(posedge TenMHzToData or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      counter     <= '0;
      shift_reg   <= '0;
      last_grant  <= 1'b1;
      trig_sync   <= '0;
      ack         <= '0;
      data_output <= 1'b0;
      dflag       <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      abort       <= 1'b0;
      missed      <= '0;
    end else begin
      trig_sync   <= {trig_sync[1:0], trgger};
      ack         <= '0;
      done        <= 1'b0;
      abort       <= 1'b0;
      dflag       <= 1'b0;
      data_output <= 1'b0;

      case (state)
        IDLE: begin
          if (trig_rise) begin
            if (req != 2'b00) begin
              shift_reg  <= grant ? data1 : data0;
              ack        <= grant ? 2'b10 : 2'b01;
              counter    <= '0;
              last_grant <= grant;
              busy       <= 1'b1;
              state      <= RUN;
            end else begin
              if (missed != 8'hFF) missed <= missed + 8'd1;
              busy  <= 1'b0;
              state <= HOLD;
            end
          end
        end

        RUN: begin
          if (counter == C_FRAME) begin
            done  <= 1'b1;
            state <= HOLD;
          end else if (trig_low) begin
            abort <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            counter <= counter + 1'b1;
            dflag   <= flag_on;
            // Word is consumed LSB first by shifting once per data slot.
            if (bit_on) begin
              data_output <= shift_reg[0];
              shift_reg   <= shift_reg >> 1;
            end
          end
        end

        HOLD: begin
          if (trig_low) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end

        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_frame_scheduler.sv
module tb_data_frame_scheduler;

  localparam int W       = 18;
  localparam int T_START = 8000;
  localparam int T_DATA  = 10000;
  localparam int T_END   = 11000;
  localparam int T_FLAG  = 1000;
  localparam int T_FRAME = 12000;

  logic          clk = 1'b0;
  logic          rst;
  logic          trgger;
  logic [1:0]    req;
  logic [W-1:0]  data0;
  logic [W-1:0]  data1;
  logic [1:0]    ack;
  logic          data_output;
  logic          dflag;
  logic          busy;
  logic          done;
  logic          abort;
  logic [7:0]    missed;

  int tests = 0;
  int fails = 0;
  int exp_missed = 0;
  logic last_g = 1'b1;

  always #5 clk = ~clk;

  data_frame_scheduler #(
    .WIDTH(W), .T_START(T_START), .T_DATA(T_DATA), .T_END(T_END),
    .T_FLAG(T_FLAG), .T_FRAME(T_FRAME), .CW(14)
  ) dut (
    .TenMHzToData(clk), .rst(rst), .trgger(trgger), .req(req),
    .data0(data0), .data1(data1), .ack(ack), .data_output(data_output),
    .dflag(dflag), .busy(busy), .done(done), .abort(abort), .missed(missed)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: cycle k counts from the cycle ack is visible (counter = k);
  // outputs reflect the counter value of the previous cycle.
  function automatic logic m_dflag(input int k);
    int c;
    c = k - 1;
    return (k >= 1) && (((c >= T_START) && (c < T_START + T_FLAG)) ||
                        ((c >= T_END) && (c < T_END + T_FLAG)));
  endfunction

  function automatic logic m_data(input int k, input logic [W-1:0] w);
    int c;
    c = k - 1;
    if ((c >= T_DATA) && (c < T_DATA + W)) return w[c - T_DATA];
    return 1'b0;
  endfunction

  // Round-robin reference: sole requester wins, otherwise alternate.
  task automatic pick(input logic [1:0] r, output logic [1:0] g);
    logic sel;
    if (r == 2'b01)      sel = 1'b0;
    else if (r == 2'b10) sel = 1'b1;
    else                 sel = !last_g;
    last_g = sel;
    g = sel ? 2'b10 : 2'b01;
  endtask

  // Runs one frame; drop_k >= 0 drops the trigger pin at that cycle (abort).
  task automatic run_frame(input string name, input logic [W-1:0] word,
                           input logic [1:0] exp_ack, input int drop_k);
    int end_k, abort_k, flag_cnt, done_cnt, abort_cnt, n;
    int bad_f, bad_d, bad_o, first_f, first_d, first_o;
    logic [W-1:0] got;
    logic seen, in_ab, e_f, e_d, e_b, e_done, e_ab;
    logic [1:0] e_ack;
    flag_cnt = 0; done_cnt = 0; abort_cnt = 0;
    bad_f = 0; bad_d = 0; bad_o = 0; first_f = -1; first_d = -1; first_o = -1;
    got = '0;
    @(negedge clk);
    trgger = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ack !== 2'b00) begin seen = 1'b1; break; end
    end
    check({name, " ack"}, {30'd0, ack}, {30'd0, exp_ack});
    if (!seen) begin
      trgger = 1'b0;
      repeat (6) @(negedge clk);
      return;
    end
    // 2-FF synchroniser then one registered step: abort visible 3 cycles on.
    abort_k = drop_k + 3;
    end_k = (drop_k >= 0) ? abort_k : T_FRAME + 1;
    for (int k = 0; k <= end_k; k++) begin
      if (k > 0) @(negedge clk);
      in_ab  = (drop_k >= 0) && (k == abort_k);
      e_f    = in_ab ? 1'b0 : m_dflag(k);
      e_d    = in_ab ? 1'b0 : m_data(k, word);
      e_b    = !in_ab;
      e_done = (drop_k < 0) && (k == end_k);
      e_ab   = in_ab;
      e_ack  = (k == 0) ? exp_ack : 2'b00;
      if (dflag !== e_f) begin bad_f++; if (first_f < 0) first_f = k; end
      if (data_output !== e_d) begin bad_d++; if (first_d < 0) first_d = k; end
      if ((busy !== e_b) || (done !== e_done) || (abort !== e_ab) || (ack !== e_ack)) begin
        bad_o++; if (first_o < 0) first_o = k;
      end
      if (dflag === 1'b1) flag_cnt++;
      if (done === 1'b1) done_cnt++;
      if (abort === 1'b1) abort_cnt++;
      if ((k >= T_DATA + 1) && (k < T_DATA + 1 + W)) got[k - T_DATA - 1] = data_output;
      if (k == drop_k) trgger = 1'b0;
    end
    tests++;
    assert (bad_f === 0) else begin
      fails++; $error("FAIL %s dflag: %0d bad cycles (first k=%0d) expected 0", name, bad_f, first_f);
    end
    tests++;
    assert (bad_d === 0) else begin
      fails++; $error("FAIL %s data_output: %0d bad cycles (first k=%0d) expected 0", name, bad_d, first_d);
    end
    tests++;
    assert (bad_o === 0) else begin
      fails++; $error("FAIL %s busy/done/abort/ack: %0d bad cycles (first k=%0d) expected 0", name, bad_o, first_o);
    end
    if (drop_k < 0) begin
      check({name, " word"}, {14'd0, got}, {14'd0, word});
      check({name, " flag_len"}, flag_cnt, 2 * T_FLAG);
      check({name, " done_cnt"}, done_cnt, 1);
      trgger = 1'b0;
      n = 0;
      while ((busy === 1'b1) && (n < 8)) begin @(negedge clk); n++; end
      check({name, " busy_release"}, {31'd0, busy}, 32'd0);
    end else begin
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        if (abort === 1'b1) abort_cnt++;
        if (done === 1'b1) done_cnt++;
      end
      check({name, " abort_cnt"}, abort_cnt, 1);
      check({name, " done_cnt"}, done_cnt, 0);
      check({name, " idle_out"}, {29'd0, busy, dflag, data_output}, 32'd0);
    end
  endtask

  initial begin
    logic [1:0] g;
    int ack_seen;
    rst = 1'b1; trgger = 1'b0; req = 2'b00; data0 = '0; data1 = '0;
    repeat (3) @(negedge clk);
    check("reset outputs", {25'd0, ack, data_output, dflag, busy, done, abort}, 32'd0);
    check("reset missed", {24'd0, missed}, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Round-robin with both sources pending on three frames.
    data0 = 18'h2AAAA;
    data1 = W'($urandom);
    req = 2'b11;
    pick(req, g); run_frame("rr0", data0, g, -1);
    pick(req, g); run_frame("rr1", data1, g, -1);
    pick(req, g); run_frame("rr2", data0, g, -1);

    // Trigger with nothing pending counts as missed and grants nothing.
    req = 2'b00;
    @(negedge clk);
    trgger = 1'b1;
    ack_seen = 0;
    repeat (6) begin @(negedge clk); if (ack !== 2'b00) ack_seen++; end
    exp_missed++;
    check("missed_one", {24'd0, missed}, exp_missed);
    check("missed_idle_out", {29'd0, busy, dflag, data_output}, 32'd0);
    // Request appears while trigger is still held: no frame.
    req = 2'b01;
    data0 = W'($urandom);
    repeat (30) begin @(negedge clk); if ((ack !== 2'b00) || (busy !== 1'b0)) ack_seen++; end
    check("held_no_frame", ack_seen, 0);
    trgger = 1'b0;
    repeat (4) @(negedge clk);

    // Abort inside the data burst, then a clean frame.
    pick(req, g); run_frame("abort", data0, g, T_DATA + 5);
    data0 = W'($urandom);
    pick(req, g); run_frame("clean", data0, g, -1);

    // Reset while the start flag is high.
    data0 = W'($urandom);
    @(negedge clk);
    trgger = 1'b1;
    ack_seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ack !== 2'b00) begin ack_seen = 1; break; end
    end
    check("rst_frame ack", ack_seen, 1);
    repeat (8500) @(negedge clk);
    check("rst_frame dflag_before", {30'd0, dflag, busy}, {30'd0, m_dflag(8500), 1'b1});
    #1 rst = 1'b1;
    #1;
    check("rst_async outputs", {25'd0, ack, data_output, dflag, busy, done, abort}, 32'd0);
    check("rst_async missed", {24'd0, missed}, 32'd0);
    trgger = 1'b0;
    exp_missed = 0;
    last_g = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    ack_seen = 0;
    repeat (5) begin @(negedge clk); if ((done !== 1'b0) || (abort !== 1'b0) || (busy !== 1'b0)) ack_seen++; end
    check("rst_release quiet", ack_seen, 0);
    check("rst_release missed", {24'd0, missed}, 32'd0);

    // Missed counter saturation.
    req = 2'b00;
    for (int i = 0; i < 257; i++) begin
      trgger = 1'b1;
      repeat (4) @(negedge clk);
      trgger = 1'b0;
      repeat (4) @(negedge clk);
      if (exp_missed < 255) exp_missed++;
      if ((i == 0) || (i >= 253)) check($sformatf("missed_sat[%0d]", i), {24'd0, missed}, exp_missed);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
